mem_arbiter: RTL and testbench

Shared-memory arbiter and address decoder for the core's memory side. It accepts an instruction-fetch port and a data port, grants one of them at a time, and decodes the granted address against the system map: IRAM, DRAM, UART and timer. It drives a single downstream bus with a one-hot slave select and routes the response back to the winning requester. Unmapped addresses are answered locally with an error and never reach the bus.

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Memory-side arbiter and address decoder: grants fetch or data onto one decoded bus.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter logic [31:0] IRAM_BASE    = 32'h0,
    parameter logic [31:0] IRAM_TOP     = 32'h20000,
    parameter logic [31:0] DRAM_BASE    = 32'h20000,
    parameter logic [31:0] DRAM_TOP     = 32'h40000,
    parameter logic [31:0] UART_BASE    = 32'h100000,
    parameter logic [31:0] UART_TOP     = 32'h100004,
    parameter logic [31:0] TIMER_BASE   = 32'h200000,
    parameter logic [31:0] TIMER_TOP    = 32'h200010,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic        imem_ready,
    output logic [31:0] imem_rdata,
    output logic        imem_err,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_ready,
    output logic [31:0] dmem_rdata,
    output logic        dmem_err,
    output logic        bus_valid,
    output logic [3:0]  bus_sel,
    output logic        bus_instr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t      state_q, state_d;
    logic        pick_instr, starve_hit, load;
    logic [31:0] req_addr, dec_off;
    logic [3:0]  dec_sel;
    logic        instr_q;
    logic [3:0]  sel_q, wstrb_q;
    logic [31:0] addr_q, wdata_q;

    // Half-open window test via wrapped offset; avoids a constant compare when base is 0.
    function automatic logic in_win(input logic [31:0] a, input logic [31:0] b, input logic [31:0] t);
        return (a - b) < (t - b);
    endfunction

    assign pick_instr = imem_valid && (!dmem_valid || starve_hit);
    assign req_addr   = pick_instr ? imem_addr : dmem_addr;

    always_comb begin
        dec_sel = '0;
        dec_off = '0;
        if (in_win(req_addr, IRAM_BASE, IRAM_TOP)) begin
            dec_sel = 4'b0001;
            dec_off = req_addr - IRAM_BASE;
        end else if (in_win(req_addr, DRAM_BASE, DRAM_TOP)) begin
            dec_sel = 4'b0010;
            dec_off = req_addr - DRAM_BASE;
        end else if (in_win(req_addr, UART_BASE, UART_TOP)) begin
            dec_sel = 4'b0100;
            dec_off = req_addr - UART_BASE;
        end else if (in_win(req_addr, TIMER_BASE, TIMER_TOP)) begin
            dec_sel = 4'b1000;
            dec_off = req_addr - TIMER_BASE;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q;

    assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));

    // Counts data grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (load) begin
            if (pick_instr || !imem_valid) begin
                starve_q <= '0;
            end else if (!starve_hit) begin
                starve_q <= starve_q + CNT_W'(1);
            end
        end
    end
`else
    logic unused_starve_limit;

    assign starve_hit          = 1'b0;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Granted request payload, captured at grant time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (load) begin
            instr_q <= pick_instr;
            sel_q   <= dec_sel;
            addr_q  <= dec_off;
            wdata_q <= pick_instr ? 32'h0 : dmem_wdata;
            wstrb_q <= pick_instr ? 4'h0 : dmem_wstrb;
        end
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        imem_err   = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        dmem_err   = 1'b0;
        bus_valid  = 1'b0;
        bus_sel    = '0;
        bus_instr  = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_wstrb  = '0;
        case (state_q)
            IDLE: begin
                if (imem_valid || dmem_valid) begin
                    load    = 1'b1;
                    state_d = (dec_sel != 4'b0000) ? BUSY : ERR;
                end
            end
            BUSY: begin
                bus_valid = 1'b1;
                bus_sel   = sel_q;
                bus_instr = instr_q;
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
                bus_wstrb = wstrb_q;
                if (bus_ready) begin
                    if (instr_q) begin
                        imem_ready = 1'b1;
                        imem_rdata = bus_rdata;
                    end else begin
                        dmem_ready = 1'b1;
                        dmem_rdata = bus_rdata;
                    end
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (instr_q) begin
                    imem_ready = 1'b1;
                    imem_err   = 1'b1;
                end else begin
                    dmem_ready = 1'b1;
                    dmem_err   = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level scoreboard plus directed scenarios.
module tb_mem_arbiter;
    localparam logic [31:0] K = 32'h5A5A0000;
    localparam int LIMIT = 8;
    localparam logic [31:0] WIN_BASE [4] = '{32'h0, 32'h20000, 32'h100000, 32'h200000};
    localparam logic [31:0] WIN_TOP  [4] = '{32'h20000, 32'h40000, 32'h100004, 32'h200010};
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        logic        instr;
        logic [3:0]  sel;
        logic [31:0] off;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic imem_valid = 1'b0, dmem_valid = 1'b0, bus_ready = 1'b0;
    logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0, bus_rdata = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic        imem_ready, imem_err, dmem_ready, dmem_err, bus_valid, bus_instr;
    logic [31:0] imem_rdata, dmem_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_sel, bus_wstrb;

    int checks = 0;
    int failures = 0;
    int slave_wait = 0;
    txn_t exp_q[$];
    logic grant_log[$];

    int          cap_lat;
    logic        cap_bus, cap_instr, cap_err;
    logic [3:0]  cap_sel, cap_wstrb;
    logic [31:0] cap_addr, cap_wdata, cap_rdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .imem_err(imem_err),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .dmem_err(dmem_err),
        .bus_valid(bus_valid), .bus_sel(bus_sel), .bus_instr(bus_instr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // System map model: which window holds the address and the offset into it.
    function automatic void model_decode(input logic [31:0] a, output logic [3:0] sel, output logic [31:0] off);
        sel = '0;
        off = '0;
        for (int i = 0; i < 4; i++) begin
            if (a >= WIN_BASE[i] && a < WIN_TOP[i]) begin
                sel[i] = 1'b1;
                off    = a - WIN_BASE[i];
            end
        end
    endfunction

    task automatic push_exp(input logic instr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        txn_t t;
        t.instr = instr;
        model_decode(a, t.sel, t.off);
        t.wdata = instr ? 32'h0 : wd;
        t.wstrb = instr ? 4'h0 : ws;
        exp_q.push_back(t);
    endtask

    // Slave: asserts bus_ready after slave_wait cycles of bus_valid; rdata tags the offset.
    initial forever begin
        int scnt;
        @(posedge clk);
        #1;
        if (bus_valid) begin
            bus_ready = (scnt >= slave_wait);
            scnt++;
        end else begin
            bus_ready = 1'b0;
            scnt = 0;
        end
        bus_rdata = bus_addr ^ K;
    end

    // Compare process: bus payload and responses against the expected transaction order.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("sel_onehot", 32'($onehot0(bus_sel)), 32'd1);
            chk("both_ready", 32'(imem_ready && dmem_ready), 32'd0);
            if (!bus_valid) chk("sel_idle", 32'(bus_sel), 32'd0);
            if (bus_valid) begin
                if (exp_q.size() == 0) begin
                    chk("bus_unexpected", 32'(bus_valid), 32'd0);
                end else begin
                    chk("bus_instr", 32'(bus_instr), 32'(exp_q[0].instr));
                    chk("bus_sel", 32'(bus_sel), 32'(exp_q[0].sel));
                    chk("bus_addr", bus_addr, exp_q[0].off);
                    chk("bus_wdata", bus_wdata, exp_q[0].wdata);
                    chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_q[0].wstrb));
                end
            end
            if (imem_ready || dmem_ready) begin
                if (exp_q.size() == 0) begin
                    chk("ready_unexpected", 32'(imem_ready || dmem_ready), 32'd0);
                end else begin
                    txn_t e;
                    logic err_e;
                    e = exp_q.pop_front();
                    err_e = (e.sel == 4'h0);
                    grant_log.push_back(imem_ready);
                    chk("resp_port", 32'(imem_ready), 32'(e.instr));
                    chk("resp_err", 32'(imem_ready ? imem_err : dmem_err), 32'(err_e));
                    chk("resp_rdata", imem_ready ? imem_rdata : dmem_rdata, err_e ? 32'h0 : (e.off ^ K));
                end
            end
        end
    end

    task automatic txn(input logic instr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        push_exp(instr, a, wd, ws);
        if (instr) begin
            imem_addr = a; imem_valid = 1'b1;
        end else begin
            dmem_addr = a; dmem_wdata = wd; dmem_wstrb = ws; dmem_valid = 1'b1;
        end
        cap_lat = 0; cap_bus = 0; cap_sel = '0; cap_addr = '0; cap_instr = 0;
        cap_wdata = '0; cap_wstrb = '0; cap_rdata = '0; cap_err = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus_valid) begin
                cap_bus = 1'b1; cap_sel = bus_sel; cap_addr = bus_addr;
                cap_instr = bus_instr; cap_wdata = bus_wdata; cap_wstrb = bus_wstrb;
            end
            if (instr ? imem_ready : dmem_ready) begin
                cap_lat   = i;
                cap_rdata = instr ? imem_rdata : dmem_rdata;
                cap_err   = instr ? imem_err : dmem_err;
            end
            @(posedge clk);
            #1;
            if (cap_lat != 0) break;
        end
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        if (cap_lat == 0) begin
            chk("txn_timeout", 32'(cap_lat), 32'd1);
            exp_q.delete();
        end
    endtask

    task automatic port_loop(input logic instr, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            logic got;
            got = 1'b0;
            if (instr) begin
                imem_addr = base + 32'(4 * k); imem_valid = 1'b1;
            end else begin
                dmem_addr = base + 32'(4 * k); dmem_valid = 1'b1;
            end
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                got = instr ? imem_ready : dmem_ready;
                @(posedge clk);
                #1;
            end
            if (!got) begin
                chk(instr ? "fetch_timeout" : "data_timeout", 32'(got), 32'd1);
                break;
            end
        end
        if (instr) imem_valid = 1'b0;
        else dmem_valid = 1'b0;
    endtask

    // Expected grant order when fetch and data both request continuously.
    task automatic predict_contested(input int nd, input int nf);
        int c = 0, d = 0, f = 0;
        while (d < nd || f < nf) begin
            logic fetch;
            if (d < nd && f < nf) fetch = GUARD && (c == LIMIT);
            else fetch = (f < nf);
            if (fetch) begin
                push_exp(1'b1, 32'h400 + 32'(4 * f), 32'h0, 4'h0);
                f++;
                c = 0;
            end else begin
                push_exp(1'b0, 32'h30000 + 32'(4 * d), dmem_wdata, 4'h0);
                d++;
                c = (f < nf) ? ((c < LIMIT) ? c + 1 : c) : 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b_addr [7];
        logic [3:0]  b_sel  [7];
        int nfetch;
        b_addr = '{32'h1FFFF, 32'h20000, 32'h100003, 32'h100004, 32'h20000F, 32'h200010, 32'hFFFFFFFC};
        b_sel  = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000};

        repeat (3) @(posedge clk);
        #2;
        chk("reset_bus_valid", 32'(bus_valid), 32'd0);
        chk("reset_bus_sel", 32'(bus_sel), 32'd0);
        chk("reset_readies", 32'({imem_ready, dmem_ready, imem_err, dmem_err}), 32'd0);
        chk("reset_bus_addr", bus_addr, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fetch with junk on the idle data port; wdata/wstrb must not leak.
        dmem_wdata = 32'h12345678; dmem_wstrb = 4'hF;
        txn(1'b1, 32'h104, 32'h0, 4'h0);
        chk("fetch_lat", 32'(cap_lat), 32'd2);
        chk("fetch_sel", 32'(cap_sel), 32'h1);
        chk("fetch_addr", cap_addr, 32'h104);
        chk("fetch_instr", 32'(cap_instr), 32'd1);
        chk("fetch_wdata", cap_wdata, 32'h0);
        chk("fetch_rdata", cap_rdata, 32'h5A5A0104);

        txn(1'b0, 32'h20010, 32'hDEADBEEF, 4'hF);
        chk("store_lat", 32'(cap_lat), 32'd2);
        chk("store_sel", 32'(cap_sel), 32'h2);
        chk("store_addr", cap_addr, 32'h10);
        chk("store_wdata", cap_wdata, 32'hDEADBEEF);
        chk("store_wstrb", 32'(cap_wstrb), 32'hF);
        chk("store_err", 32'(cap_err), 32'd0);

        txn(1'b0, 32'h300000, 32'h0, 4'h0);
        chk("unmapped_bus", 32'(cap_bus), 32'd0);
        chk("unmapped_lat", 32'(cap_lat), 32'd2);
        chk("unmapped_err", 32'(cap_err), 32'd1);
        chk("unmapped_rdata", cap_rdata, 32'h0);

        for (int i = 0; i < 7; i++) begin
            txn(i[0], b_addr[i], 32'h0, 4'h0);
            chk("bound_sel", 32'(cap_sel), 32'(b_sel[i]));
            chk("bound_err", 32'(cap_err), 32'(b_sel[i] == 4'h0));
        end

        slave_wait = 3;
        txn(1'b0, 32'h200004, 32'h0, 4'h0);
        chk("wait_lat", 32'(cap_lat), 32'd5);
        chk("wait_rdata", cap_rdata, 32'h5A5A0004);
        slave_wait = 0;

        // Both ports requesting back to back.
        dmem_wdata = 32'hCAFE0000; dmem_wstrb = 4'h0;
        grant_log.delete();
        predict_contested(18, 2);
        fork
            port_loop(1'b1, 2, 32'h400);
            port_loop(1'b0, 18, 32'h30000);
        join
        repeat (2) @(posedge clk);
        #1;
        chk("contested_count", 32'(grant_log.size()), 32'd20);
        nfetch = 0;
        for (int i = 0; i < 18 && i < grant_log.size(); i++) nfetch += int'(grant_log[i]);
        if (GUARD) begin
            chk("guard_first_fetch", 32'(grant_log.size() > 8 ? grant_log[8] : 1'b0), 32'd1);
            chk("guard_second_fetch", 32'(grant_log.size() > 17 ? grant_log[17] : 1'b0), 32'd1);
            chk("guard_fetch_in_18", 32'(nfetch), 32'd2);
        end else begin
            chk("strict_fetch_in_18", 32'(nfetch), 32'd0);
        end
        exp_q.delete();

        // Reset while BUSY with the slave stalled.
        slave_wait = 1000;
        push_exp(1'b0, 32'h20004, 32'h0, 4'h0);
        dmem_addr = 32'h20004; dmem_wdata = 32'h0; dmem_wstrb = 4'h0; dmem_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_valid) break;
        end
        chk("rst_pre_busy", 32'(bus_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_ready", 32'({imem_ready, dmem_ready}), 32'd0);
        exp_q.delete();
        slave_wait = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        txn(1'b0, 32'h20004, 32'h0, 4'h0);
        chk("rst_regrant_lat", 32'(cap_lat), 32'd2);
        chk("rst_regrant_rdata", cap_rdata, 32'h5A5A0004);
        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
